// File: rtl/pri_enc8to3_q_pkg.sv
// Shared definitions for the queued 8-to-3 priority encoder.
//   N        : code width
//   REQ_W    : request vector width (2**N)
//   LAST_RST : reset value of the round-robin pointer. The search starts at LAST+1,
//              so this value makes the first search start at index 0.
package pri_enc8to3_q_pkg;
  localparam int unsigned N     = 3;
  localparam int unsigned REQ_W = 2 ** N;

  typedef logic [N-1:0]     code_t;
  typedef logic [REQ_W-1:0] req_vec_t;

  localparam code_t LAST_RST = 3'b111;

  // One-hot mask for a code, used to clear the bit being issued from pending.
  function automatic req_vec_t onehot(input code_t c);
    req_vec_t v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/pri_enc8to3_q_pick.sv
// pri_pick8: combinational request picker.
//   cand : candidate requests, bit i is request index i
//   last : index issued most recently (round-robin pointer)
//   sel  : chosen index
//   any  : at least one candidate is set
// RR=0 picks the lowest set index. RR=1 rotates cand so that index last+1 lands
// at position 0, picks the lowest set bit there, then un-rotates the result.
module pri_pick8
  import pri_enc8to3_q_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic [REQ_W-1:0] cand,
  input  logic [N-1:0]     last,
  output logic [N-1:0]     sel,
  output logic             any
);

  code_t    start;
  code_t    offset;
  req_vec_t rot;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    start  = '0;
    offset = '0;
    rot    = '0;
    sel    = '0;
    any    = |cand;

    // The code width wraps naturally, so 7+1 becomes 0.
    if (RR) start = last + code_t'(1);

    for (int i = 0; i < REQ_W; i++) begin
      rot[i] = cand[code_t'(i) + start];
    end

    // Scan downward so the lowest set position is the one that sticks.
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (rot[i]) offset = code_t'(i);
    end

    sel = offset + start;
  end

endmodule

// File: rtl/pri_enc8to3_q.sv
// pri_enc8to3_q: queued 8-to-3 priority encoder with a Valid/Ack handshake.
// Request lines are OR-ed into a pending vector every edge. One index at a time
// is issued on code, held until acknowledged.
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears all state and drops req/ack that cycle
//   en    : 1 allows a new issue; requests are captured regardless
//   req   : request lines, bit i maps to code i
//   ack   : consumer accepts code; ignored while valid=0
//   valid : code holds an issued, unacknowledged index
//   code  : index being serviced
//   pend  : captured requests not yet issued
//   busy  : |pend | valid
module pri_enc8to3_q
  import pri_enc8to3_q_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [REQ_W-1:0] req,
  input  logic             ack,
  output logic             valid,
  output logic [N-1:0]     code,
  output logic [REQ_W-1:0] pend,
  output logic             busy
);

  req_vec_t cand;
  code_t    last;
  code_t    sel;
  logic     any;
  logic     free;
  logic     issue;

  assign cand  = pend | req;
  // The output slot is free when empty or being acknowledged this edge, which
  // lets a new code follow an ack with no bubble.
  assign free  = !valid || ack;
  assign issue = en && free && any;
  assign busy  = (|pend) || valid;

  pri_pick8 #(
    .RR(RR)
  ) u_pick (
    .cand(cand),
    .last(last),
    .sel (sel),
    .any (any)
  );

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      valid <= 1'b0;
      code  <= '0;
      pend  <= '0;
      last  <= LAST_RST;
    end else if (issue) begin
      valid <= 1'b1;
      code  <= sel;
      pend  <= cand & ~onehot(sel);
      last  <= sel;
    end else begin
      // A held req on the bit now on code is re-pended here, so it is serviced again.
      if (valid && ack) valid <= 1'b0;
      pend <= cand;
    end
  end

endmodule

// File: tb/tb_pri_enc8to3_q.sv
// Directed bench for pri_enc8to3_q. Two instances share stimulus: dut0 uses
// fixed priority, dut1 round-robin.
module tb_pri_enc8to3_q;

  logic       clock;
  logic       reset;
  logic       en;
  logic [7:0] req;
  logic       ack;

  logic       valid0, valid1;
  logic [2:0] code0, code1;
  logic [7:0] pend0, pend1;
  logic       busy0, busy1;

  int checks;
  int failures;

  pri_enc8to3_q #(.RR(1'b0)) dut0 (
    .clock(clock), .reset(reset), .en(en), .req(req), .ack(ack),
    .valid(valid0), .code(code0), .pend(pend0), .busy(busy0)
  );

  pri_enc8to3_q #(.RR(1'b1)) dut1 (
    .clock(clock), .reset(reset), .en(en), .req(req), .ack(ack),
    .valid(valid1), .code(code1), .pend(pend1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; ack = 1'b0; en = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'hFF; ack = 1'b1; en = 1'b1;
    step(); step();
    checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid0 got=%b exp=0", valid0); end
    checks++; if (code0 !== 3'b000) begin failures++; $display("FAIL reset_code0 got=%b exp=000", code0); end
    checks++; if (pend0 !== 8'h00) begin failures++; $display("FAIL reset_pend0 got=%h exp=00", pend0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    checks++; if ({valid1, code1, pend1, busy1} !== 13'b0) begin failures++; $display("FAIL reset_dut1 got=%b/%b/%h/%b exp=all zero", valid1, code1, pend1, busy1); end
    reset = 1'b0; req = 8'h00; ack = 1'b0;
    step();
    checks++; if (valid0 !== 1'b0 || pend0 !== 8'h00) begin failures++; $display("FAIL release_idle got valid=%b pend=%h exp valid=0 pend=00", valid0, pend0); end
  endtask

  task automatic test_single();
    req = 8'h20; ack = 1'b0;
    step();
    checks++; if (valid0 !== 1'b1 || code0 !== 3'b101 || pend0 !== 8'h00) begin failures++; $display("FAIL single_issue got valid=%b code=%b pend=%h exp 1/101/00", valid0, code0, pend0); end
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (valid0 !== 1'b1 || code0 !== 3'b101) begin failures++; $display("FAIL single_hold%0d got valid=%b code=%b exp 1/101", i, valid0, code0); end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL single_ack got valid=%b busy=%b exp 0/0", valid0, busy0); end
    checks++; if (code0 !== 3'b101) begin failures++; $display("FAIL single_code_hold got=%b exp=101", code0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h44; ack = 1'b1;
    step();
    req = 8'h00;
    checks++; if (valid0 !== 1'b1 || code0 !== 3'b010 || pend0 !== 8'h40) begin failures++; $display("FAIL b2b_first got valid=%b code=%b pend=%h exp 1/010/40", valid0, code0, pend0); end
    step();
    checks++; if (valid0 !== 1'b1 || code0 !== 3'b110 || pend0 !== 8'h00) begin failures++; $display("FAIL b2b_second got valid=%b code=%b pend=%h exp 1/110/00", valid0, code0, pend0); end
    step();
    checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL b2b_drain got valid=%b busy=%b exp 0/0", valid0, busy0); end
    ack = 1'b0;
  endtask

  task automatic test_hold_rr();
    logic [2:0] exp_rr;
    do_reset();
    req = 8'h03; ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_rr = (i % 2 == 0) ? 3'b000 : 3'b001;
      checks++; if (valid0 !== 1'b1 || code0 !== 3'b000) begin failures++; $display("FAIL hold_fixed%0d got valid=%b code=%b exp 1/000", i, valid0, code0); end
      checks++; if (valid1 !== 1'b1 || code1 !== exp_rr) begin failures++; $display("FAIL hold_rr%0d got valid=%b code=%b exp 1/%b", i, valid1, code1, exp_rr); end
    end
    checks++; if (pend0 !== 8'h02) begin failures++; $display("FAIL hold_fixed_pend got=%h exp=02", pend0); end
    req = 8'h00; ack = 1'b0;
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; req = 8'h08; ack = 1'b0;
    step();
    req = 8'h00;
    checks++; if (valid0 !== 1'b0 || pend0 !== 8'h08 || busy0 !== 1'b1) begin failures++; $display("FAIL en_off_capture got valid=%b pend=%h busy=%b exp 0/08/1", valid0, pend0, busy0); end
    step();
    checks++; if (valid0 !== 1'b0 || pend0 !== 8'h08) begin failures++; $display("FAIL en_off_hold got valid=%b pend=%h exp 0/08", valid0, pend0); end
    en = 1'b1;
    step();
    checks++; if (valid0 !== 1'b1 || code0 !== 3'b011 || pend0 !== 8'h00) begin failures++; $display("FAIL en_on_issue got valid=%b code=%b pend=%h exp 1/011/00", valid0, code0, pend0); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL en_ack got valid=%b exp 0", valid0); end
  endtask

  task automatic test_saturate();
    do_reset();
    req = 8'hFF; ack = 1'b0;
    step();
    checks++; if (valid0 !== 1'b1 || code0 !== 3'b000 || pend0 !== 8'hFE) begin failures++; $display("FAIL sat_issue got valid=%b code=%b pend=%h exp 1/000/FE", valid0, code0, pend0); end
    step();
    checks++; if (pend0 !== 8'hFF || code0 !== 3'b000) begin failures++; $display("FAIL sat_full got pend=%h code=%b exp FF/000", pend0, code0); end
    req = 8'h00;
    step();
    checks++; if (pend0 !== 8'hFF) begin failures++; $display("FAIL sat_stay got pend=%h exp FF", pend0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h91; ack = 1'b0;
    step();
    checks++; if (valid0 !== 1'b1 || code0 !== 3'b000 || pend0 !== 8'h90) begin failures++; $display("FAIL mid_setup got valid=%b code=%b pend=%h exp 1/000/90", valid0, code0, pend0); end
    reset = 1'b1; req = 8'h02;
    step();
    checks++; if (valid0 !== 1'b0 || code0 !== 3'b000 || pend0 !== 8'h00 || busy0 !== 1'b0) begin failures++; $display("FAIL mid_reset got valid=%b code=%b pend=%h busy=%b exp 0/000/00/0", valid0, code0, pend0, busy0); end
    reset = 1'b0; req = 8'h00;
    step();
    checks++; if (valid0 !== 1'b0 || pend0 !== 8'h00) begin failures++; $display("FAIL mid_req_lost got valid=%b pend=%h exp 0/00", valid0, pend0); end
  endtask

  task automatic test_ack_idle();
    req = 8'h00; ack = 1'b1;
    step(); step();
    ack = 1'b0;
    checks++; if (valid0 !== 1'b0 || code0 !== 3'b000 || pend0 !== 8'h00 || busy0 !== 1'b0) begin failures++; $display("FAIL ack_idle got valid=%b code=%b pend=%h busy=%b exp 0/000/00/0", valid0, code0, pend0, busy0); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; en = 1'b1; req = '0; ack = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_rr();
    test_enable();
    test_saturate();
    test_reset_mid();
    test_ack_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
